// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access-size codes,
// clear-engine state encoding and the word-index width helper.
package dmem_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 8;

    // Access size as presented on the size port.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    // Clear engine: CLEAR zeroes one word per cycle, IDLE serves accesses.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Bits needed to index a memory of 'depth' words (at least one bit).
    function automatic int unsigned word_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Access bus of the data memory controller.
//   master: drives rd/wr/size/sext/addr/wdata/clr_req/err_clr,
//           receives rdata/busy/err/err_sticky.
//   slave : the controller side.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    import dmem_pkg::*;

    logic                rd;
    logic                wr;
    logic [1:0]          size;
    logic                sext;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                clr_req;
    logic                err_clr;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic                err;
    logic                err_sticky;

    modport master (
        output rd, wr, size, sext, addr, wdata, clr_req, err_clr,
        input  rdata, busy, err, err_sticky
    );

    modport slave (
        input  rd, wr, size, sext, addr, wdata, clr_req, err_clr,
        output rdata, busy, err, err_sticky
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the bus and a 32-bit memory word.
//   size, sext, byte_off : access descriptor (byte_off = addr[1:0])
//   wdata                : right-justified store data
//   rword                : current contents of the addressed word
//   be_c                 : byte enables for a store
//   wdata_rep_c          : store data replicated onto every candidate lane
//   rdata_ext_c          : selected lanes shifted to bit 0 and extended
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [LANES-1:0]  be_c,
    output logic [DATA_W-1:0] wdata_rep_c,
    output logic [DATA_W-1:0] rdata_ext_c
);

    logic [7:0]  lane8_c;
    logic [15:0] lane16_c;

    // Enables, replication and load extraction per access size.
    always_comb begin
        be_c        = '0;
        wdata_rep_c = '0;
        rdata_ext_c = '0;
        lane8_c     = rword[{byte_off, 3'b000} +: 8];
        lane16_c    = byte_off[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B: begin
                be_c        = 4'b0001 << byte_off;
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_ext_c = {{24{sext & lane8_c[7]}}, lane8_c};
            end
            SZ_H: begin
                be_c        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_ext_c = {{16{sext & lane16_c[15]}}, lane16_c};
            end
            SZ_W: begin
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
                rdata_ext_c = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable 32-bit data memory with combinational loads, lane-masked
// stores, a whole-memory clear engine and illegal-access flags.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (starts a full clear)
//   bus   : data_mem_ctrl_if.slave access port
// ADDR_W must be at least $clog2(DEPTH_WORDS)+2.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);

    localparam int unsigned IDX_W   = word_idx_w(DEPTH_WORDS);
    localparam int unsigned BYTE_AW = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              err_sticky_q, err_sticky_d;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              busy_c;
    logic              in_range_c;
    logic              align_ok_c;
    logic              legal_c;
    logic              err_c;
    logic              st_we_c;
    logic              clr_we_c;
    logic [IDX_W-1:0]  word_idx_c;
    logic [DATA_W-1:0] rword_c;
    logic [LANES-1:0]  be_c;
    logic [DATA_W-1:0] wdata_rep_c;
    logic [DATA_W-1:0] rdata_ext_c;

    // Address is in range when no bit above the byte-address span is set.
    if (ADDR_W > BYTE_AW) begin : g_range
        assign in_range_c = (bus.addr[ADDR_W-1:BYTE_AW] == '0);
    end else begin : g_no_range
        assign in_range_c = 1'b1;
    end

    assign word_idx_c = bus.addr[BYTE_AW-1:2];
    assign rword_c    = mem_q[word_idx_c];

    dmem_lane_align u_lane_align (
        .size        (bus.size),
        .sext        (bus.sext),
        .byte_off    (bus.addr[1:0]),
        .wdata       (bus.wdata),
        .rword       (rword_c),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_ext_c (rdata_ext_c)
    );

    // Legality, error flag and write strobes for the current access.
    always_comb begin
        busy_c     = (state_q == ST_CLEAR);
        align_ok_c = 1'b0;
        case (bus.size)
            SZ_B:    align_ok_c = 1'b1;
            SZ_H:    align_ok_c = ~bus.addr[0];
            SZ_W:    align_ok_c = (bus.addr[1:0] == 2'b00);
            default: align_ok_c = 1'b0;
        endcase
        legal_c  = ~busy_c & in_range_c & align_ok_c;
        err_c    = (bus.rd | bus.wr) & ~busy_c & ~legal_c;
        st_we_c  = bus.wr & legal_c;
        // No zeroing writes while reset is held, so memory keeps its contents.
        clr_we_c = busy_c & reset;
    end

    assign bus.rdata      = (bus.rd & legal_c) ? rdata_ext_c : '0;
    assign bus.busy       = busy_c;
    assign bus.err        = err_c;
    assign bus.err_sticky = err_sticky_q;

    // Clear-engine next state and sticky error update.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        err_sticky_d = err_sticky_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
        // A new error wins over a same-cycle clear request.
        if (err_c) begin
            err_sticky_d = 1'b1;
        end else if (bus.err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Storage: either a zeroing write from the clear engine or a lane-masked store.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (st_we_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_c[i]) begin
                    mem_q[word_idx_c][LANE_W*i +: LANE_W] <= wdata_rep_c[LANE_W*i +: LANE_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scenarios plus randomized traffic for data_mem_ctrl, checked
// against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int DEPTH  = 16;
    localparam int NBYTES = 4 * DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(32)) bus ();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    byte unsigned m_mem [NBYTES];
    int           m_left;   // zeroing cycles still to run
    bit           m_rst;    // reset currently held low
    bit           m_sticky;

    logic [31:0] last_rdata;
    logic        last_err;
    int          busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int m_nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
        if (m_rst || m_left > 0) return 1'b0;
        if (a >= 32'(NBYTES))    return 1'b0;
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return (a % 2) == 0;
            2'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Little-endian assembly of n bytes, then two's-complement extension.
    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sx, input logic [31:0] a);
        int     n = m_nbytes(sz);
        int     b = int'(a);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(m_mem[b + i]) << (8 * i);
        if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    // One bus cycle: drive, check against the model, then advance the model at the edge.
    task automatic cyc(input string nm, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a, input logic [31:0] wd,
                       input bit clr, input bit ec);
        bit          busy_e;
        bit          legal;
        bit          err_e;
        logic [31:0] rd_e;
        int          n;
        int          base;
        bus.rd = rd; bus.wr = wr; bus.size = sz; bus.sext = sx;
        bus.addr = a; bus.wdata = wd; bus.clr_req = clr; bus.err_clr = ec;
        #3;
        busy_e = m_rst || (m_left > 0);
        legal  = m_legal(sz, a);
        err_e  = (rd || wr) && !busy_e && !legal;
        rd_e   = (rd && legal) ? m_load(sz, sx, a) : 32'h0;
        last_rdata = bus.rdata;
        last_err   = bus.err;
        if (bus.busy === 1'b1) busy_cnt++;
        chk({nm, ".busy"},       32'(bus.busy),       32'(busy_e));
        chk({nm, ".err"},        32'(bus.err),        32'(err_e));
        chk({nm, ".rdata"},      bus.rdata,           rd_e);
        chk({nm, ".err_sticky"}, 32'(bus.err_sticky), 32'(m_sticky));
        @(posedge clk);
        if (!m_rst) begin
            if (busy_e) begin
                base = 4 * (DEPTH - m_left);
                for (int k = 0; k < 4; k++) m_mem[base + k] = 8'h00;
                m_left--;
            end else begin
                if (wr && legal) begin
                    n    = m_nbytes(sz);
                    base = int'(a);
                    for (int i = 0; i < n; i++) m_mem[base + i] = 8'(wd >> (8 * i));
                end
                if (clr) m_left = DEPTH;
            end
            if (err_e)   m_sticky = 1'b1;
            else if (ec) m_sticky = 1'b0;
        end
        #1;
    endtask

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.sext = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.clr_req = 1'b0; bus.err_clr = 1'b0;
        for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
        busy_cnt = 0;

        // Reset held across several edges: busy, no data, no error.
        #1 reset = 1'b0;
        m_rst = 1'b1; m_left = DEPTH; m_sticky = 1'b0;
        @(posedge clk); #1;
        repeat (3) cyc("rst_hold", 1, 1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 0, 1);

        // Release: exactly DEPTH busy cycles, word reads return 0.
        reset = 1'b1; m_rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) cyc("clr0", 1, 0, 2'd2, 0, 32'(4 * i), 32'h0, 0, 0);
        chk("s037_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        chk("s037_busy_done", 32'(bus.busy), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc("s037_read", 1, 0, 2'd2, 0, 32'(4 * i), 32'h0, 0, 0);
            chk("s037_zero", last_rdata, 32'h0);
        end

        // Word store then byte merge; signed and unsigned byte loads.
        cyc("s038_sw", 0, 1, 2'd2, 0, 32'h8, 32'h11223344, 0, 0);
        cyc("s038_sb", 0, 1, 2'd0, 0, 32'h9, 32'h123456AA, 0, 0);
        cyc("s038_lw", 1, 0, 2'd2, 0, 32'h8, 32'h0, 0, 0);
        chk("s038_word", last_rdata, 32'h1122AA44);
        cyc("s038_lbs", 1, 0, 2'd0, 1, 32'h9, 32'h0, 0, 0);
        chk("s038_byte_sext", last_rdata, 32'hFFFFFFAA);
        cyc("s038_lbz", 1, 0, 2'd0, 0, 32'h9, 32'h0, 0, 0);
        chk("s038_byte_zext", last_rdata, 32'h000000AA);

        // Halfword store/load and misaligned halfword accesses.
        cyc("s039_sh", 0, 1, 2'd1, 0, 32'hE, 32'hFFFF8001, 0, 0);
        cyc("s039_lh", 1, 0, 2'd1, 1, 32'hE, 32'h0, 0, 0);
        chk("s039_half_sext", last_rdata, 32'hFFFF8001);
        cyc("s039_lh_mis", 1, 0, 2'd1, 1, 32'hD, 32'h0, 0, 0);
        chk("s039_mis_err", 32'(last_err), 32'h1);
        chk("s039_mis_rdata", last_rdata, 32'h0);
        cyc("s039_sh_mis", 0, 1, 2'd1, 0, 32'hD, 32'h00001234, 0, 0);
        cyc("s039_lw", 1, 0, 2'd2, 0, 32'hC, 32'h0, 0, 0);
        chk("s039_unchanged", last_rdata, 32'h80010000);

        // Out-of-range store; sticky set beats a same-cycle clear.
        cyc("s040_oob", 0, 1, 2'd2, 0, 32'(NBYTES), 32'hFFFFFFFF, 0, 0);
        chk("s040_err", 32'(last_err), 32'h1);
        chk("s040_sticky_set", 32'(bus.err_sticky), 32'h1);
        cyc("s040_both", 0, 1, 2'd2, 0, 32'(NBYTES), 32'h0, 0, 1);
        chk("s040_sticky_hold", 32'(bus.err_sticky), 32'h1);
        cyc("s040_clr", 0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 1);
        chk("s040_sticky_clr", 32'(bus.err_sticky), 32'h0);

        // Same-word read during write sees old data, new data next cycle.
        cyc("s042_init", 0, 1, 2'd2, 0, 32'h20, 32'h5, 0, 0);
        cyc("s042_rw", 1, 1, 2'd2, 0, 32'h20, 32'h7, 0, 0);
        chk("s042_old", last_rdata, 32'h5);
        cyc("s042_rd", 1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 0);
        chk("s042_new", last_rdata, 32'h7);

        // Clear request with a store, re-request ignored, reset at clr_ptr=5.
        cyc("s041_err", 1, 0, 2'd3, 0, 32'h0, 32'h0, 0, 0);
        cyc("s041_req", 0, 1, 2'd2, 0, 32'h28, 32'hCAFEF00D, 1, 0);
        chk("s041_busy", 32'(bus.busy), 32'h1);
        repeat (5) cyc("s041_run", 1, 1, 2'd2, 0, 32'h28, 32'h12345678, 1, 0);
        reset = 1'b0;
        m_rst = 1'b1; m_left = DEPTH; m_sticky = 1'b0;
        #2;
        chk("s041_rst_busy", 32'(bus.busy), 32'h1);
        chk("s041_rst_sticky", 32'(bus.err_sticky), 32'h0);
        chk("s041_rst_rdata", bus.rdata, 32'h0);
        chk("s041_rst_err", 32'(bus.err), 32'h0);
        reset = 1'b1; m_rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) cyc("s041_clr", 1, 1, 2'd2, 0, 32'(4 * i), 32'hFFFFFFFF, 1, 0);
        chk("s041_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        cyc("s041_after", 1, 0, 2'd2, 0, 32'h28, 32'h0, 0, 0);
        chk("s041_zeroed", last_rdata, 32'h0);
        chk("s041_idle", 32'(bus.busy), 32'h0);

        // Randomized traffic against the model.
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, NBYTES + 7));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            cyc("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
